// File: rtl/servo_position_sequencer_pkg.sv
// Shared definitions for the servo position sequencer.
//  - FSM state encodings (IDLE/SLEW/DONE), kept as plain 2-bit constants so the
//    encodings line up with the existing servo controller code and its benches.
//  - Default parameter values for one servo channel.
//  - slew_step(): one frame's worth of motion from a position toward a target.
package servo_position_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SLEW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned DEF_FRAME_CLKS  = 2_000_000;  // 20 ms at 100 MHz
  localparam int unsigned DEF_MULTIPLY_BY = 753;
  localparam int unsigned DEF_POS_MAX     = 255;
  localparam int unsigned DEF_POS_RESET   = 128;
  localparam int unsigned DEF_STEP_MAX    = 4;

  // Move pos toward tgt by at most step. When the remaining distance fits in
  // one step the result lands exactly on the target, so it can never overshoot
  // and never leaves the interval between pos and tgt.
  function automatic logic [7:0] slew_step(input logic [7:0] pos,
                                           input logic [7:0] tgt,
                                           input logic [3:0] step);
    logic signed [8:0] diff;
    logic [8:0]        mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    mag  = diff[8] ? 9'(-diff) : 9'(diff);
    if (mag <= {5'd0, step}) begin
      return tgt;
    end else if (diff[8]) begin
      return pos - {4'd0, step};
    end else begin
      return pos + {4'd0, step};
    end
  endfunction

endpackage

// File: rtl/servo_position_sequencer_frame_timer.sv
// Free-running PWM frame timer, reusable by any servo channel.
//  Counts 0..FRAME_CLKS-1 and wraps; o_Tick is high for the single cycle in
//  which the count equals FRAME_CLKS-1.
// Ports:
//  i_Clk   system clock
//  i_Rst   asynchronous reset, active-high (count returns to 0)
//  o_Tick  one-cycle end-of-frame pulse
module servo_position_sequencer_frame_timer #(
  parameter int unsigned FRAME_CLKS = 2_000_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  output logic o_Tick
);

  localparam int unsigned CW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CLKS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign o_Tick = (count == LAST);

endmodule

// File: rtl/servo_position_sequencer.sv
// Servo position sequencer: accepts target-position commands, slews the
// commanded position toward the target by a bounded step once per PWM frame,
// and drives the PWM generator's control range with position*MULTIPLY_BY.
// Ports:
//  i_Clk            system clock (100 MHz)
//  i_Rst            asynchronous reset, active-high
//  i_Cmd_Valid      command valid
//  i_Cmd_Pos [7:0]  target position (clamped to POS_MAX)
//  i_Cmd_Step[3:0]  step per frame; 0 selects STEP_MAX, larger values clamp to STEP_MAX
//  o_Cmd_Ready      command can be accepted (IDLE)
//  i_Abort          stop an active slew at the current position
//  o_Control_Range  registered position*MULTIPLY_BY, one cycle behind o_Position
//  o_Position       current commanded position
//  o_Busy           slew in progress
//  o_Done           one-cycle pulse when the target is reached
//  o_Frame_Tick     one-cycle pulse at the end of each frame
//  o_Dbg_State      FSM state (ST_IDLE/ST_SLEW/ST_DONE) for observation
//
// Command handshake: a command transfers on a rising clock edge where
// i_Cmd_Valid and o_Cmd_Ready are both 1. o_Cmd_Ready depends only on the FSM
// state (never on i_Cmd_Valid); i_Cmd_Pos/i_Cmd_Step are sampled only on the
// transfer edge.
module servo_position_sequencer
  import servo_position_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_CLKS  = DEF_FRAME_CLKS,
  parameter int unsigned MULTIPLY_BY = DEF_MULTIPLY_BY,
  parameter int unsigned POS_MAX     = DEF_POS_MAX,
  parameter int unsigned POS_RESET   = DEF_POS_RESET,
  parameter int unsigned STEP_MAX    = DEF_STEP_MAX
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Cmd_Valid,
  input  logic [7:0]  i_Cmd_Pos,
  input  logic [3:0]  i_Cmd_Step,
  output logic        o_Cmd_Ready,
  input  logic        i_Abort,
  output logic [23:0] o_Control_Range,
  output logic [7:0]  o_Position,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Frame_Tick,
  output logic [1:0]  o_Dbg_State
);

  // The full-scale control range must fit the 24-bit output.
  if ((POS_MAX * MULTIPLY_BY) >= (1 << 24)) begin : g_range_check
    $error("POS_MAX*MULTIPLY_BY does not fit in 24 bits");
  end

  localparam logic [7:0]  POS_MAX_L   = 8'(POS_MAX);
  localparam logic [7:0]  POS_RESET_L = 8'(POS_RESET);
  localparam logic [3:0]  STEP_MAX_L  = 4'(STEP_MAX);
  localparam logic [23:0] MULT_L      = 24'(MULTIPLY_BY);
  localparam logic [23:0] RANGE_RESET = 24'(POS_RESET * MULTIPLY_BY);

  logic [1:0] state;
  logic [7:0] position;
  logic [7:0] target;
  logic [3:0] step;
  logic       tick;
  logic [7:0] cmd_target;
  logic [3:0] cmd_step;

  servo_position_sequencer_frame_timer #(
    .FRAME_CLKS(FRAME_CLKS)
  ) u_frame_timer (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .o_Tick(tick)
  );

  // Command conditioning: clamp the target into range, and map step 0 (and
  // anything too large) to STEP_MAX.
  always_comb begin
    cmd_target = (i_Cmd_Pos > POS_MAX_L) ? POS_MAX_L : i_Cmd_Pos;
    if (i_Cmd_Step == 4'd0 || i_Cmd_Step > STEP_MAX_L) begin
      cmd_step = STEP_MAX_L;
    end else begin
      cmd_step = i_Cmd_Step;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= ST_IDLE;
      position <= POS_RESET_L;
      target   <= POS_RESET_L;
      step     <= STEP_MAX_L;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_Cmd_Valid) begin
            target <= cmd_target;
            step   <= cmd_step;
            state  <= ST_SLEW;
          end
        end
        ST_SLEW: begin
          // Abort outranks both arrival and a same-cycle frame tick, so an
          // aborted slew never moves and never reports done.
          if (i_Abort) begin
            state <= ST_IDLE;
          end else if (position == target) begin
            state <= ST_DONE;
          end else if (tick) begin
            position <= slew_step(position, target, step);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered scaling; follows o_Position by one cycle.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Control_Range <= RANGE_RESET;
    end else begin
      o_Control_Range <= {16'd0, position} * MULT_L;
    end
  end

  assign o_Cmd_Ready  = (state == ST_IDLE);
  assign o_Busy       = (state == ST_SLEW);
  assign o_Done       = (state == ST_DONE);
  assign o_Frame_Tick = tick;
  assign o_Position   = position;
  assign o_Dbg_State  = state;

endmodule

// File: tb/tb_servo_position_sequencer.sv
module tb_servo_position_sequencer;

  localparam int FRAME = 100;
  localparam int LIMIT = 70 * FRAME + 20;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_pos;
  logic [3:0]  cmd_step;
  logic        cmd_ready;
  logic        abort;
  logic [23:0] control_range;
  logic [7:0]  position;
  logic        busy;
  logic        done;
  logic        frame_tick;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  servo_position_sequencer #(
    .FRAME_CLKS(FRAME)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Cmd_Valid    (cmd_valid),
    .i_Cmd_Pos      (cmd_pos),
    .i_Cmd_Step     (cmd_step),
    .o_Cmd_Ready    (cmd_ready),
    .i_Abort        (abort),
    .o_Control_Range(control_range),
    .o_Position     (position),
    .o_Busy         (busy),
    .o_Done         (done),
    .o_Frame_Tick   (frame_tick),
    .o_Dbg_State    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic send_cmd(input logic [7:0] p, input logic [3:0] s);
    int t;
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_before_send", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_pos   = p;
    cmd_step  = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts frame ticks seen while slewing until o_Done; positions after ticks
  // are compared against exp_q while it holds entries.
  task automatic wait_done(output int ticks, output int got);
    logic pend;
    ticks = 0;
    got   = 0;
    pend  = 1'b0;
    for (int c = 0; c < LIMIT; c++) begin
      if (pend) begin
        check("traj_pos", int'(position), int'(exp_q.pop_front()));
        pend = 1'b0;
      end
      if (done) begin
        got = 1;
        break;
      end
      if (frame_tick && busy) begin
        ticks++;
        if (exp_q.size() != 0) pend = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  // Waits for n slew ticks, then one more edge so the move is visible.
  task automatic wait_ticks(input int n, output int got);
    int cnt;
    cnt = 0;
    got = 0;
    for (int c = 0; c < (n + 1) * FRAME + 10; c++) begin
      if (frame_tick && busy) cnt++;
      @(negedge clk);
      if (cnt == n) begin
        got = 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  pos;
    logic [3:0]  step;
    logic [7:0]  exp_pos;
    int          exp_ticks;
    int          exp_range;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int ticks, got, dn, gap;

    // Vectors run back to back; each starts where the previous one ended.
    vecs[0] = '{8'd137, 4'd9,  8'd137, 1,  103161};  // from 140, step clamped to 4
    vecs[1] = '{8'd128, 4'd2,  8'd128, 5,  96384};   // 135,133,131,129,128
    vecs[2] = '{8'd255, 4'd0,  8'd255, 32, 192015};  // full-scale, step 0 -> 4
    vecs[3] = '{8'd0,   4'd15, 8'd0,   64, 0};       // down to 0, no wrap
    vecs[4] = '{8'd10,  4'd3,  8'd10,  4,  7530};    // 3,6,9,10

    rst = 1'b1; cmd_valid = 1'b0; cmd_pos = '0; cmd_step = '0; abort = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_position", int'(position), 128);
    check("rst_range", int'(control_range), 96384);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_state", int'(dbg_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // Frame tick period
    gap = 0;
    for (int c = 0; c < 2 * FRAME && !frame_tick; c++) @(negedge clk);
    check("tick_found", int'(frame_tick), 1);
    @(negedge clk);
    for (int c = 0; c < 2 * FRAME && !frame_tick; c++) begin
      gap++;
      @(negedge clk);
    end
    check("tick_period", gap + 1, FRAME);

    // 128 -> 140 step 4 with per-tick trajectory
    exp_q.push_back(8'd132);
    exp_q.push_back(8'd136);
    exp_q.push_back(8'd140);
    send_cmd(8'd140, 4'd4);
    check("slew_busy", int'(busy), 1);
    check("slew_ready", int'(cmd_ready), 0);
    wait_done(ticks, got);
    check("traj_done_seen", got, 1);
    check("traj_ticks", ticks, 3);
    check("traj_queue_empty", exp_q.size(), 0);
    check("traj_range", int'(control_range), 105420);
    check("traj_done_busy", int'(busy), 0);
    @(negedge clk);
    check("traj_done_pulse", int'(done), 0);

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      send_cmd(vecs[i].pos, vecs[i].step);
      wait_done(ticks, got);
      check($sformatf("v%0d_done_seen", i), got, 1);
      check($sformatf("v%0d_ticks", i), ticks, vecs[i].exp_ticks);
      check($sformatf("v%0d_pos", i), int'(position), int'(vecs[i].exp_pos));
      check($sformatf("v%0d_range", i), int'(control_range), vecs[i].exp_range);
      check($sformatf("v%0d_busy", i), int'(busy), 0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check($sformatf("v%0d_ready", i), int'(cmd_ready), 1);
    end

    // Asynchronous reset in the middle of a slew (10 -> 200)
    send_cmd(8'd200, 4'd4);
    wait_ticks(2, got);
    check("mid_rst_ticks", got, 1);
    check("mid_rst_pre_pos", int'(position), 18);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_position", int'(position), 128);
    check("mid_rst_range", int'(control_range), 96384);
    check("mid_rst_ready", int'(cmd_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_state", int'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Abort after two ticks of 128 -> 200, raised in a tick cycle
    send_cmd(8'd200, 4'd4);
    wait_ticks(2, got);
    check("abort_ticks", got, 1);
    check("abort_pre_pos", int'(position), 136);
    for (int c = 0; c < 2 * FRAME && !frame_tick; c++) @(negedge clk);
    check("abort_tick_cycle", int'(frame_tick), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_pos_hold", int'(position), 136);
    check("abort_ready", int'(cmd_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_state", int'(dbg_state), 0);
    dn = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    check("abort_pos_after", int'(position), 136);
    check("abort_range", int'(control_range), 102408);

    // Same-position command, with abort asserted in IDLE (ignored)
    cmd_valid = 1'b1; cmd_pos = 8'd136; cmd_step = 4'd1; abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    check("same_busy_c1", int'(busy), 1);
    check("same_done_c1", int'(done), 0);
    @(negedge clk);
    check("same_done_c2", int'(done), 1);
    check("same_pos", int'(position), 136);
    @(negedge clk);
    check("same_done_c3", int'(done), 0);
    check("same_ready_c3", int'(cmd_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
